addr_gen_arbiter: RTL and testbench

ADDR_GEN_ARBITER -- requirements
Module: addr_gen_arbiter

---
 rtl/addr_gen_arbiter.sv | 97 +++++++++
 tb/tb_addr_gen_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/addr_gen_arbiter.sv
// rtl/addr_gen_arbiter.sv - two-requester round-robin arbiter driving a linear address sweep
module addr_gen_arbiter #(
   parameter int ADDR_W = 13
) (
   input  logic              clk,
   input  logic              rstx,
   input  logic              req0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] base0,
   input  logic [ADDR_W-1:0] base1,
   input  logic [ADDR_W-1:0] cnt0,
   input  logic [ADDR_W-1:0] cnt1,
   input  logic              ack,
   output logic              gnt0,
   output logic              gnt1,
   output logic              done0,
   output logic              done1,
   output logic [ADDR_W-1:0] addr,
   output logic              addr_valid,
   output logic              last,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] rem_q, rem_d;
   logic              sel_q, sel_d;
   // prio_q names the requester that wins the next tie
   logic              prio_q, prio_d;
   logic              pick;

   always_ff @(posedge clk) begin
      if (rstx) begin
         state_q <= IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         sel_q   <= 1'b0;
         prio_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         sel_q   <= sel_d;
         prio_q  <= prio_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      sel_d   = sel_q;
      prio_d  = prio_q;
      pick    = (req0 && req1) ? prio_q : req1;
      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               sel_d   = pick;
               addr_d  = pick ? base1 : base0;
               rem_d   = pick ? cnt1 : cnt0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (ack) begin
               if (rem_q == '0) begin
                  state_d = DONE;
               end else begin
                  addr_d = addr_q + ADDR_W'(1);
                  rem_d  = rem_q - ADDR_W'(1);
               end
            end
         end
         DONE: begin
            prio_d  = ~sel_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign addr_valid = (state_q == RUN);
   assign gnt0       = addr_valid && !sel_q;
   assign gnt1       = addr_valid && sel_q;
   assign done0      = (state_q == DONE) && !sel_q;
   assign done1      = (state_q == DONE) && sel_q;
   assign last       = addr_valid && (rem_q == '0);
   assign busy       = (state_q != IDLE);
   assign addr       = addr_q;

endmodule

// File: tb/tb_addr_gen_arbiter.sv
// tb/tb_addr_gen_arbiter.sv - directed self-checking bench for addr_gen_arbiter
module tb_addr_gen_arbiter;

   logic        clk = 1'b0;
   logic        rstx;
   logic        req0, req1, ack;
   logic [12:0] base0, base1, cnt0, cnt1;
   logic        gnt0, gnt1, done0, done1, addr_valid, last, busy;
   logic [12:0] addr;
   logic [6:0]  flags;
   int          errors = 0;
   int          checks = 0;

   // flag order: gnt0 gnt1 done0 done1 addr_valid last busy
   localparam logic [6:0] F_IDLE  = 7'b0000000;
   localparam logic [6:0] F_RUN0  = 7'b1000101;
   localparam logic [6:0] F_LAST0 = 7'b1000111;
   localparam logic [6:0] F_RUN1  = 7'b0100101;
   localparam logic [6:0] F_LAST1 = 7'b0100111;
   localparam logic [6:0] F_DONE0 = 7'b0010001;
   localparam logic [6:0] F_DONE1 = 7'b0001001;

   addr_gen_arbiter #(.ADDR_W(13)) dut (
      .clk(clk), .rstx(rstx),
      .req0(req0), .req1(req1),
      .base0(base0), .base1(base1),
      .cnt0(cnt0), .cnt1(cnt1),
      .gnt0(gnt0), .gnt1(gnt1),
      .done0(done0), .done1(done1),
      .addr(addr), .addr_valid(addr_valid),
      .ack(ack), .last(last), .busy(busy)
   );

   always #5 clk = ~clk;

   assign flags = {gnt0, gnt1, done0, done1, addr_valid, last, busy};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic [6:0] f_exp, input logic [12:0] a_exp);
      checks++;
      assert (flags === f_exp)
      else begin
         errors++;
         $error("FAIL %s flags observed=%b expected=%b", tag, flags, f_exp);
      end
      checks++;
      assert (addr === a_exp)
      else begin
         errors++;
         $error("FAIL %s addr observed=%0d expected=%0d", tag, addr, a_exp);
      end
   endtask

   initial begin
      rstx = 1'b1; req0 = 1'b0; req1 = 1'b0; ack = 1'b0;
      base0 = '0; base1 = '0; cnt0 = '0; cnt1 = '0;
      tick(); tick();
      rstx = 1'b0;
      expect_out("reset", F_IDLE, 13'd0);

      // basic sweep of requester 0, ack held high
      req0 = 1'b1; base0 = 13'd100; cnt0 = 13'd3; ack = 1'b1;
      tick(); req0 = 1'b0;
      expect_out("sweep_a100", F_RUN0, 13'd100);
      tick(); expect_out("sweep_a101", F_RUN0, 13'd101);
      tick(); expect_out("sweep_a102", F_RUN0, 13'd102);
      tick(); expect_out("sweep_a103_last", F_LAST0, 13'd103);
      tick(); expect_out("sweep_done0", F_DONE0, 13'd103);
      tick(); expect_out("sweep_idle", F_IDLE, 13'd103);

      // tie after reset: requester 0 first, then requester 1
      rstx = 1'b1; tick(); rstx = 1'b0;
      expect_out("tie_reset", F_IDLE, 13'd0);
      req0 = 1'b1; req1 = 1'b1;
      base0 = 13'd10; cnt0 = 13'd1; base1 = 13'd20; cnt1 = 13'd0; ack = 1'b1;
      tick(); expect_out("tie_gnt0", F_RUN0, 13'd10);
      tick(); expect_out("tie_gnt0_last", F_LAST0, 13'd11);
      tick(); expect_out("tie_done0", F_DONE0, 13'd11);
      tick(); expect_out("tie_idle", F_IDLE, 13'd11);
      tick(); expect_out("tie_gnt1", F_LAST1, 13'd20);
      tick(); expect_out("tie_done1", F_DONE1, 13'd20);
      tick(); expect_out("tie_idle2", F_IDLE, 13'd20);
      tick(); expect_out("tie_gnt0_again", F_RUN0, 13'd10);
      req0 = 1'b0; req1 = 1'b0;
      tick(); tick();
      expect_out("tie_done0_again", F_DONE0, 13'd11);
      tick();

      // address wraps past all-ones
      req1 = 1'b1; base1 = 13'd8190; cnt1 = 13'd3; ack = 1'b1;
      tick(); req1 = 1'b0;
      expect_out("wrap_8190", F_RUN1, 13'd8190);
      tick(); expect_out("wrap_8191", F_RUN1, 13'd8191);
      tick(); expect_out("wrap_0", F_RUN1, 13'd0);
      tick(); expect_out("wrap_1_last", F_LAST1, 13'd1);
      tick(); expect_out("wrap_done1", F_DONE1, 13'd1);
      tick(); expect_out("wrap_idle", F_IDLE, 13'd1);

      // ack in IDLE ignored; ack pattern 1,0,0,1 in RUN
      ack = 1'b1;
      tick(); expect_out("ack_idle", F_IDLE, 13'd1);
      req0 = 1'b1; base0 = 13'd50; cnt0 = 13'd2; ack = 1'b0;
      tick(); req0 = 1'b0;
      expect_out("ackp_start", F_RUN0, 13'd50);
      ack = 1'b1; tick(); expect_out("ackp_1", F_RUN0, 13'd51);
      ack = 1'b0; tick(); expect_out("ackp_0a", F_RUN0, 13'd51);
      ack = 1'b0; tick(); expect_out("ackp_0b", F_RUN0, 13'd51);
      ack = 1'b1; tick(); expect_out("ackp_1b_last", F_LAST0, 13'd52);
      tick(); expect_out("ackp_done0", F_DONE0, 13'd52);
      tick(); ack = 1'b0;
      expect_out("ackp_idle", F_IDLE, 13'd52);

      // reset mid-run abandons region without done
      req0 = 1'b1; base0 = 13'd200; cnt0 = 13'd5; ack = 1'b1;
      tick(); req0 = 1'b0;
      expect_out("abort_a200", F_RUN0, 13'd200);
      tick(); expect_out("abort_a201", F_RUN0, 13'd201);
      rstx = 1'b1;
      tick(); rstx = 1'b0;
      expect_out("abort_reset", F_IDLE, 13'd0);
      tick(); expect_out("abort_nodone", F_IDLE, 13'd0);
      req1 = 1'b1; base1 = 13'd300; cnt1 = 13'd1; ack = 1'b1;
      tick(); req1 = 1'b0;
      expect_out("abort_gnt1", F_RUN1, 13'd300);
      tick(); expect_out("abort_gnt1_last", F_LAST1, 13'd301);
      tick(); expect_out("abort_done1", F_DONE1, 13'd301);
      tick();

      // single-word region
      req0 = 1'b1; base0 = 13'd7; cnt0 = 13'd0; ack = 1'b0;
      tick(); req0 = 1'b0;
      expect_out("single_last", F_LAST0, 13'd7);
      tick(); expect_out("single_hold", F_LAST0, 13'd7);
      ack = 1'b1;
      tick(); expect_out("single_done0", F_DONE0, 13'd7);
      tick(); expect_out("single_idle", F_IDLE, 13'd7);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
